alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU operand/opcode interface.
- Accepts one RV32I R-type, I-type ALU or B-type instruction with its register operands over a valid/ready handshake, then decodes it into the 4-bit ALU opcode and operands.
- Drives the ALU, waits a programmable number of cycles, and samples result and flags.
- Returns the write-back result or branch decision over a second valid/ready handshake.
- Sits between the register-read stage and write-back/PC-select in the multi-cycle core.

---
 rtl/alu_issue_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one RV32I R-type, I-type ALU or B-type instruction
// with its operands, decodes it for an external ALU, holds the ALU inputs for
// ALU_LATENCY cycles (legal range 1..4), samples the result, and returns the
// write-back value or branch decision.
//
// Both handshakes are strict valid/ready: a transfer happens on a rising edge
// where valid and ready are both high. in_ready depends only on state, never
// on in_valid. Once out_valid rises, it and every out_* field stay constant
// until the edge where out_ready is seen high.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic        alu_negative,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_is_branch,
  output logic        out_branch_taken,
  output logic        out_illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRA  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_B = 7'b1100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Wait counter is loaded with LATENCY-1 so the sample happens on the edge
  // that ends the last held cycle.
  localparam logic [1:0] LAT_M1 = 2'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_next;
  logic        accept;
  logic        sample;
  logic [1:0]  cnt;
  logic [2:0]  br_kind;
  logic        br_flag;
  logic        br_taken;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [3:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_illegal;
  logic        dec_branch;

  // rd/rs1 fields are resolved upstream and the negative flag is not needed
  // by any supported operation.
  logic        unused_inputs;
  assign unused_inputs = ^{alu_negative, instr[19:15], instr[11:7]};

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Decode the presented instruction into ALU opcode/operands and legality.
  always_comb begin
    dec_op      = OP_ADD;
    dec_a       = rs1_val;
    dec_b       = rs2_val;
    dec_illegal = 1'b0;
    dec_branch  = 1'b0;
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'b000:  dec_op = OP_ADD;
            3'b001:  dec_op = OP_SLL;
            3'b010:  dec_op = OP_SLT;
            3'b011:  dec_op = OP_SLTU;
            3'b100:  dec_op = OP_XOR;
            3'b101:  dec_op = OP_SRL;
            3'b110:  dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_op = OP_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_op = OP_SRA;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OPC_I: begin
        dec_b = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000: dec_op = OP_ADD;
          3'b001: begin
            dec_op = OP_SLL;
            dec_b  = {27'd0, instr[24:20]};
            if (funct7 != F7_BASE) dec_illegal = 1'b1;
          end
          3'b010: dec_op = OP_SLT;
          3'b011: dec_op = OP_SLTU;
          3'b100: dec_op = OP_XOR;
          3'b101: begin
            dec_b = {27'd0, instr[24:20]};
            if (funct7 == F7_BASE)     dec_op = OP_SRL;
            else if (funct7 == F7_ALT) dec_op = OP_SRA;
            else                       dec_illegal = 1'b1;
          end
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
      OPC_B: begin
        dec_branch = 1'b1;
        case (funct3)
          3'b000, 3'b001: dec_op = OP_SUB;
          3'b100, 3'b101: dec_op = OP_SLT;
          3'b110, 3'b111: dec_op = OP_SLTU;
          default:        dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Branch condition from the sampled ALU outputs; SLT/SLTU use result bit 0.
  always_comb begin
    br_taken = 1'b0;
    case (br_kind)
      3'b000:         br_taken = alu_zero;
      3'b001:         br_taken = !alu_zero;
      3'b100, 3'b110: br_taken = alu_result[0];
      3'b101, 3'b111: br_taken = !alu_result[0];
      default:        br_taken = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus handshake outputs and datapath strobes.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = dec_illegal ? RESP : EXEC;
        end
      end
      EXEC: begin
        if (cnt == 2'd0) begin
          sample     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU drive registers, wait counter and response registers. An illegal
  // instruction leaves the ALU inputs untouched and responds immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_op           <= OP_ADD;
      alu_a            <= '0;
      alu_b            <= '0;
      cnt              <= '0;
      br_kind          <= '0;
      br_flag          <= 1'b0;
      out_result       <= '0;
      out_is_branch    <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else begin
      if (accept && !dec_illegal) begin
        alu_op  <= dec_op;
        alu_a   <= dec_a;
        alu_b   <= dec_b;
        cnt     <= LAT_M1;
        br_kind <= funct3;
        br_flag <= dec_branch;
      end
      if (accept && dec_illegal) begin
        out_result       <= '0;
        out_is_branch    <= 1'b0;
        out_branch_taken <= 1'b0;
        out_illegal      <= 1'b1;
      end
      if (sample) begin
        out_result       <= br_flag ? 32'd0 : alu_result;
        out_is_branch    <= br_flag;
        out_branch_taken <= br_flag & br_taken;
        out_illegal      <= 1'b0;
      end else if (state == EXEC) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: two instances (ALU_LATENCY 1 and 3) each driven by
// directed and random instructions, checked every cycle against a
// transaction-level model of the block.
module tb_alu_issue_ctrl;

  int tests_run    = 0;
  int tests_failed = 0;

  // Clock and reset-free generation; each lane drives its own reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Base-funct3 opcode table for the non-alternate R/I encodings.
  localparam logic [3:0] R_OPS [8] = '{4'd0, 4'd5, 4'd8, 4'd7, 4'd3, 4'd9, 4'd2, 4'd4};

  typedef struct packed {
    logic        illegal;
    logic        is_branch;
    logic        taken;
    logic [31:0] result;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } resp_t;

  task automatic chk(input int lane_id, input string name,
                     input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL lane%0d %s: got 0x%0h, expected 0x%0h", lane_id, name, act, exp);
    end
  endtask

  // Reference ALU: plain arithmetic for each opcode.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a | b;
      4'd3:    return a ^ b;
      4'd4:    return a & b;
      4'd5:    return a << b[4:0];
      4'd6:    return $unsigned($signed(a) >>> b[4:0]);
      4'd7:    return {31'd0, a < b};
      4'd8:    return {31'd0, $signed(a) < $signed(b)};
      4'd9:    return a >> b[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Expected outcome of one instruction; branch decisions come straight from
  // comparing the operands rather than from ALU flags.
  function automatic resp_t model_decode(input logic [31:0] ins, input logic [31:0] r1,
                                         input logic [31:0] r2);
    resp_t      d;
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    d = '0;
    d.a = r1;
    d.b = r2;
    if (ins[6:0] == 7'b0110011) begin
      if (f7 == 7'h00)                     d.op = R_OPS[f3];
      else if (f7 == 7'h20 && f3 == 3'd0)  d.op = 4'd1;
      else if (f7 == 7'h20 && f3 == 3'd5)  d.op = 4'd6;
      else                                 d.illegal = 1'b1;
    end else if (ins[6:0] == 7'b0010011) begin
      d.op = R_OPS[f3];
      d.b  = {{20{ins[31]}}, ins[31:20]};
      if (f3 == 3'd1 || f3 == 3'd5) begin
        d.b = {27'd0, ins[24:20]};
        if (f3 == 3'd5 && f7 == 7'h20) d.op = 4'd6;
        else if (f7 != 7'h00)          d.illegal = 1'b1;
      end
    end else if (ins[6:0] == 7'b1100011) begin
      d.is_branch = 1'b1;
      case (f3)
        3'd0:    begin d.op = 4'd1; d.taken = (r1 == r2); end
        3'd1:    begin d.op = 4'd1; d.taken = (r1 != r2); end
        3'd4:    begin d.op = 4'd8; d.taken = ($signed(r1) < $signed(r2)); end
        3'd5:    begin d.op = 4'd8; d.taken = ($signed(r1) >= $signed(r2)); end
        3'd6:    begin d.op = 4'd7; d.taken = (r1 < r2); end
        3'd7:    begin d.op = 4'd7; d.taken = (r1 >= r2); end
        default: d.illegal = 1'b1;
      endcase
    end else begin
      d.illegal = 1'b1;
    end
    if (d.illegal) begin
      d = '0;
      d.illegal = 1'b1;
    end else if (!d.is_branch) begin
      d.result = alu_fn(d.op, d.a, d.b);
    end
    return d;
  endfunction

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3);
    return {imm, 5'd1, f3, 5'd3, 7'b0010011};
  endfunction

  function automatic logic [31:0] b_ins(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'b01000, 7'b1100011};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0]  f7;
    r  = $urandom();
    f7 = ($urandom_range(0, 3) == 0) ? r[31:25] : (r[31] ? 7'h20 : 7'h00);
    case ($urandom_range(0, 3))
      0:       return {f7, r[24:7], 7'b0110011};
      1:       return {f7, r[24:7], 7'b0010011};
      2:       return {r[31:7], 7'b1100011};
      default: return r;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] instr, rs1_val, rs2_val, alu_a, alu_b, alu_result, out_result;
    logic [3:0]  alu_op;
    logic        alu_zero, alu_negative, out_is_branch, out_branch_taken, out_illegal;

    bit          done     = 1'b0;
    bit          checking = 1'b0;

    logic        exec;
    int          ecnt  = 0;
    logic [31:0] noise = '0;

    logic        m_busy = 1'b0;
    int          m_wait = 0;
    logic [3:0]  m_op   = '0;
    logic [31:0] m_a    = '0;
    logic [31:0] m_b    = '0;
    resp_t       m_res  = '0;
    resp_t       m_pend = '0;

    logic [3:0]  got_op;
    logic [31:0] got_a, got_b, got_result;
    logic        got_branch, got_taken, got_illegal;
    int          got_lat;
    logic [31:0] t_ins, t_r1, t_r2;

    alu_issue_ctrl #(.ALU_LATENCY(LAT)) dut (
      .clk              (clk),
      .rst              (rst),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .instr            (instr),
      .rs1_val          (rs1_val),
      .rs2_val          (rs2_val),
      .alu_op           (alu_op),
      .alu_a            (alu_a),
      .alu_b            (alu_b),
      .alu_result       (alu_result),
      .alu_zero         (alu_zero),
      .alu_negative     (alu_negative),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_result       (out_result),
      .out_is_branch    (out_is_branch),
      .out_branch_taken (out_branch_taken),
      .out_illegal      (out_illegal)
    );

    // ALU stand-in: correct result only in the last held cycle, noise otherwise.
    assign exec = !in_ready && !out_valid;
    always @(posedge clk) ecnt <= exec ? ecnt + 1 : 0;
    always @(negedge clk) noise <= $urandom();
    assign alu_result   = (exec && ecnt == LAT - 1) ? alu_fn(alu_op, alu_a, alu_b) : noise;
    assign alu_zero     = (alu_result == 32'd0);
    assign alu_negative = noise[31];

    // Transaction model: busy from accept until the response is taken,
    // response visible after LAT cycles (immediately for illegal).
    always @(posedge clk) begin
      if (rst) begin
        m_busy = 1'b0;
        m_wait = 0;
        m_op   = '0;
        m_a    = '0;
        m_b    = '0;
        m_res  = '0;
      end else if (!m_busy) begin
        if (in_valid) begin
          m_pend = model_decode(instr, rs1_val, rs2_val);
          m_busy = 1'b1;
          if (m_pend.illegal) begin
            m_wait = 0;
            m_res  = m_pend;
          end else begin
            m_wait = LAT;
            m_op   = m_pend.op;
            m_a    = m_pend.a;
            m_b    = m_pend.b;
          end
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_res = m_pend;
      end else if (out_ready) begin
        m_busy = 1'b0;
      end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
      if (checking) begin
        chk(g, "in_ready", 32'(in_ready), 32'(!m_busy));
        chk(g, "out_valid", 32'(out_valid), 32'(m_busy && m_wait == 0));
        chk(g, "alu_op", 32'(alu_op), 32'(m_op));
        chk(g, "alu_a", alu_a, m_a);
        chk(g, "alu_b", alu_b, m_b);
        if (m_busy && m_wait == 0) begin
          chk(g, "out_result", out_result, m_res.result);
          chk(g, "out_is_branch", 32'(out_is_branch), 32'(m_res.is_branch));
          chk(g, "out_branch_taken", 32'(out_branch_taken), 32'(m_res.taken));
          chk(g, "out_illegal", 32'(out_illegal), 32'(m_res.illegal));
        end
      end
    end

    task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      instr    = ins;
      rs1_val  = r1;
      rs2_val  = r2;
      while (!in_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) chk(g, "accept_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      instr    = $urandom();
      rs1_val  = $urandom();
      rs2_val  = $urandom();
    endtask

    task automatic do_txn(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2,
                          input int stall, input bit pulse);
      int n;
      out_ready = (stall == 0);
      send(ins, r1, r2);
      got_op = alu_op;
      got_a  = alu_a;
      got_b  = alu_b;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      got_lat = n;
      if (n >= 20) chk(g, "resp_timeout", 32'(out_valid), 32'd1);
      got_result  = out_result;
      got_branch  = out_is_branch;
      got_taken   = out_branch_taken;
      got_illegal = out_illegal;
      for (int i = 0; i < stall; i++) begin
        in_valid = pulse;
        instr    = r_ins(7'h00, 3'b000);
        @(negedge clk);
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
    endtask

    task automatic reset_mid(input bit in_resp);
      int n;
      n = 0;
      out_ready = !in_resp;
      send(r_ins(7'h00, 3'b000), 32'd3, 32'd4);
      if (in_resp) begin
        while (!out_valid && n < 20) begin
          @(negedge clk);
          n++;
        end
      end
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      out_ready = 1'b1;
      chk(g, "rst_mid_in_ready", 32'(in_ready), 32'd1);
      chk(g, "rst_mid_out_valid", 32'(out_valid), 32'd0);
      chk(g, "rst_mid_alu_op", 32'(alu_op), 32'd0);
      repeat (LAT + 2) @(negedge clk);
      chk(g, "dropped_no_resp", 32'(out_valid), 32'd0);
    endtask

    // Driver: reset, directed cases with literal expectations, mid-flight
    // resets, then random traffic.
    initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      instr     = '0;
      rs1_val   = '0;
      rs2_val   = '0;
      repeat (3) @(negedge clk);
      checking = 1'b1;
      chk(g, "reset_in_ready", 32'(in_ready), 32'd1);
      chk(g, "reset_out_valid", 32'(out_valid), 32'd0);
      chk(g, "reset_alu_op", 32'(alu_op), 32'd0);
      chk(g, "reset_alu_a", alu_a, 32'd0);
      chk(g, "reset_out_result", out_result, 32'd0);
      chk(g, "reset_out_illegal", 32'(out_illegal), 32'd0);
      rst = 1'b0;

      do_txn(r_ins(7'h00, 3'b000), 32'd5, 32'd7, 0, 1'b0);
      chk(g, "add_op", 32'(got_op), 32'd0);
      chk(g, "add_a", got_a, 32'd5);
      chk(g, "add_b", got_b, 32'd7);
      chk(g, "add_latency", 32'(got_lat), 32'(LAT));
      chk(g, "add_result", got_result, 32'd12);
      chk(g, "add_is_branch", 32'(got_branch), 32'd0);

      do_txn(i_ins({7'h20, 5'd4}, 3'b101), 32'h8000_0000, 32'd0, 0, 1'b0);
      chk(g, "srai_op", 32'(got_op), 32'd6);
      chk(g, "srai_b", got_b, 32'd4);
      chk(g, "srai_result", got_result, 32'hF800_0000);

      do_txn(i_ins({7'h20, 5'd4}, 3'b001), 32'd1, 32'd2, 0, 1'b0);
      chk(g, "slli_bad_illegal", 32'(got_illegal), 32'd1);
      chk(g, "slli_bad_op_kept", 32'(got_op), 32'd6);
      chk(g, "slli_bad_result", got_result, 32'd0);
      chk(g, "slli_bad_latency", 32'(got_lat), 32'd0);

      do_txn(b_ins(3'b110), 32'd1, 32'hFFFF_FFFF, 0, 1'b0);
      chk(g, "bltu_op", 32'(got_op), 32'd7);
      chk(g, "bltu_taken", 32'(got_taken), 32'd1);
      chk(g, "bltu_is_branch", 32'(got_branch), 32'd1);

      do_txn(b_ins(3'b100), 32'd1, 32'hFFFF_FFFF, 0, 1'b0);
      chk(g, "blt_op", 32'(got_op), 32'd8);
      chk(g, "blt_taken", 32'(got_taken), 32'd0);

      do_txn(b_ins(3'b000), 32'd9, 32'd9, 0, 1'b0);
      chk(g, "beq_op", 32'(got_op), 32'd1);
      chk(g, "beq_taken", 32'(got_taken), 32'd1);
      chk(g, "beq_result", got_result, 32'd0);

      do_txn(i_ins(12'hFFF, 3'b000), 32'd1, 32'd0, 5, 1'b1);
      chk(g, "addi_b", got_b, 32'hFFFF_FFFF);
      chk(g, "addi_latency", 32'(got_lat), 32'(LAT));
      chk(g, "addi_result", got_result, 32'd0);
      chk(g, "addi_stall_held", out_result, 32'd0);

      reset_mid(1'b0);
      reset_mid(1'b1);

      for (int t = 0; t < 150; t++) begin
        t_ins = rand_instr();
        t_r1  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
        case ($urandom_range(0, 3))
          0:       t_r2 = t_r1;
          1:       t_r2 = 32'($urandom_range(0, 40));
          default: t_r2 = $urandom();
        endcase
        repeat ($urandom_range(0, 2)) @(negedge clk);
        do_txn(t_ins, t_r1, t_r2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clk);
      done = 1'b1;
    end
  end

  // Final report once both lanes finish, bounded by a cycle budget.
  initial begin
    int cyc;
    cyc = 0;
    while (!(lane[0].done && lane[1].done) && cyc < 50000) begin
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 50000) begin
      tests_run++;
      tests_failed++;
      $display("FAIL lanes_done: got timeout after %0d cycles, expected completion", cyc);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
